pipelined_cond_sum_adder: RTL and testbench

Parametrised, pipelined conditional-sum adder for operands of WIDTH bits, with a valid/ready handshake on both sides. It is the streaming successor to the fixed 8-bit combinational conditional-sum adder. It sits between operand-producing datapath logic and result consumers that may apply backpressure. A global-stall pipeline holds every in-flight result until the consumer takes it.

---
 rtl/pipelined_cond_sum_adder.sv | 147 ++++++++++++++
 tb/tb_pipelined_cond_sum_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cond_sum_adder.sv
// Pipelined conditional-sum adder with valid/ready handshake and global-stall pipeline.
// Define CSA_SUB_EN to add the op_sub port (a - b via ~b plus forced carry-in).
module pipelined_cond_sum_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;
    localparam int R = STAGES - 1;

    // s0/c0: block results assuming block carry-in 0; s1/c1: carry-in 1.
    // c0/c1 are indexed by block number at the current level.
    typedef struct packed {
        logic         vld;
        logic         ci;
        logic         amsb;
        logic         bmsb;
        logic [P-1:0] s0;
        logic [P-1:0] s1;
        logic [P-1:0] c0;
        logic [P-1:0] c1;
    } lvl_t;

    // Rank r sits after merge level ceil(r*L/(R+1)); distinct and >= 1 for R <= L.
    function automatic bit is_rank(input int k);
        for (int r = 1; r <= R; r++)
            if ((r * L + R) / (R + 1) == k) return 1'b1;
        return 1'b0;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef CSA_SUB_EN
    assign b_eff = op_sub ? ~b : b;
    assign c_eff = op_sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    for (genvar k = 0; k <= L; k++) begin : lv
        lvl_t c;
        lvl_t q;
        logic unused_lv;

        if (k == 0) begin : g_pair
            logic [P-1:0] ax, bx;
            assign ax = P'(a);
            assign bx = P'(b_eff);
            always_comb begin
                c      = '0;
                c.vld  = in_valid;
                c.ci   = c_eff;
                c.amsb = a[WIDTH-1];
                c.bmsb = b_eff[WIDTH-1];
                c.s0   = ax ^ bx;
                c.s1   = ~(ax ^ bx);
                c.c0   = ax & bx;
                c.c1   = ax | bx;
            end
            assign unused_lv = ^q;
        end else begin : g_merge
            localparam int H = 1 << (k - 1);
            lvl_t p;
            assign p = lv[k-1].q;
            // Lower half is already final; upper half picks its pair by the lower carry.
            always_comb begin
                c    = p;
                c.c0 = '0;
                c.c1 = '0;
                for (int j = 0; j < (P >> k); j++) begin
                    c.s0[(2*j+1)*H +: H] = p.c0[2*j] ? p.s1[(2*j+1)*H +: H] : p.s0[(2*j+1)*H +: H];
                    c.s1[(2*j+1)*H +: H] = p.c1[2*j] ? p.s1[(2*j+1)*H +: H] : p.s0[(2*j+1)*H +: H];
                    c.c0[j] = p.c0[2*j] ? p.c1[2*j+1] : p.c0[2*j+1];
                    c.c1[j] = p.c1[2*j] ? p.c1[2*j+1] : p.c0[2*j+1];
                end
            end
            assign unused_lv = ^{p, q};
        end

        if (k > 0 && is_rank(k)) begin : g_reg
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)
                    q <= '0;
                else if (advance) begin
                    if (c.vld) q <= c;
                    else       q.vld <= 1'b0;
                end
        end else begin : g_wire
            assign q = c;
        end
    end

    lvl_t         f;
    logic [P-1:0] fs;
    logic         fcout;
    logic         unused_f;

    assign f  = lv[L].q;
    assign fs = f.ci ? f.s1 : f.s0;

    // Zero padding propagates the real carry into bit WIDTH of the padded sum.
    if (P > WIDTH) begin : g_pad
        assign fcout = fs[WIDTH];
    end else begin : g_nopad
        assign fcout = f.ci ? f.c1[0] : f.c0[0];
    end

    assign unused_f = ^{f, fs};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= f.vld;
            if (f.vld) begin
                sum  <= fs[WIDTH-1:0];
                cout <= fcout;
                ovf  <= (f.amsb == f.bmsb) && (fs[WIDTH-1] != f.amsb);
            end
        end

endmodule

// File: tb/tb_pipelined_cond_sum_adder.sv
// Directed and randomized checks for pipelined_cond_sum_adder (8-bit main, 13-bit sweep).
module tb_pipelined_cond_sum_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [7:0]  a, b, sum;
    logic        in_valid13, cin13, out_ready_1, out_ready_5;
    logic [12:0] a13, b13, sum_1, sum_5;
    logic        in_ready_1, out_valid_1, cout_1, ovf_1;
    logic        in_ready_5, out_valid_5, cout_5, ovf_5;
`ifdef CSA_SUB_EN
    logic        op_sub, op_sub13;
`endif

    pipelined_cond_sum_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CSA_SUB_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_cond_sum_adder #(.WIDTH(13), .STAGES(1)) dut13_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready_1),
        .a(a13), .b(b13), .cin(cin13),
`ifdef CSA_SUB_EN
        .op_sub(op_sub13),
`endif
        .out_valid(out_valid_1), .out_ready(out_ready_1), .sum(sum_1), .cout(cout_1), .ovf(ovf_1));

    pipelined_cond_sum_adder #(.WIDTH(13), .STAGES(5)) dut13_s5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready_5),
        .a(a13), .b(b13), .cin(cin13),
`ifdef CSA_SUB_EN
        .op_sub(op_sub13),
`endif
        .out_valid(out_valid_5), .out_ready(out_ready_5), .sum(sum_5), .cout(cout_5), .ovf(ovf_5));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add of zero-extended operands.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic c);
        logic [64:0] s;
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        s = 65'(x) + 65'(y) + 65'(c);
        return {(x[w-1] == y[w-1]) && (s[w-1] != x[w-1]), s[w], s[63:0] & m};
    endfunction

    logic [7:0]  va [6] = '{8'd2, 8'd1, 8'd20, 8'd75, 8'd128, 8'd200};
    logic [7:0]  vb [6] = '{8'd5, 8'd1, 8'd20, 8'd75, 8'd128, 8'd20};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  es [6] = '{8'd7, 8'd2, 8'd41, 8'd151, 8'd0, 8'd220};
    logic        eco[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        eov[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic [65:0] qb[$];
    logic [65:0] q1[$];
    logic [65:0] q5[$];
    logic [65:0] e;
    logic [8:0]  held;
    int          sent, got;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0; out_ready_1 = 1'b1; out_ready_5 = 1'b1;
`ifdef CSA_SUB_EN
        op_sub = 1'b0; op_sub13 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 66'(out_valid), 66'(0));
        chk("rst_sum", 66'(sum), 66'(0));
        chk("rst_cout", 66'(cout), 66'(0));
        chk("rst_ovf", 66'(ovf), 66'(0));
        chk("rst_in_ready", 66'(in_ready), 66'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back directed adds: beat n visible right after edge n+2.
        for (int n = 0; n < 9; n++) begin
            if (n < 6) begin
                in_valid = 1'b1; a = va[n]; b = vb[n]; cin = vc[n];
            end else
                in_valid = 1'b0;
            @(posedge clk); #1;
            if (n >= 1 && n <= 6) begin
                chk($sformatf("add%0d_valid", n-1), 66'(out_valid), 66'(1));
                chk($sformatf("add%0d_sum", n-1), 66'(sum), 66'(es[n-1]));
                chk($sformatf("add%0d_cout", n-1), 66'(cout), 66'(eco[n-1]));
                chk($sformatf("add%0d_ovf", n-1), 66'(ovf), 66'(eov[n-1]));
            end else
                chk($sformatf("add_idle%0d_valid", n), 66'(out_valid), 66'(0));
        end

        // Backpressure: out_ready low for cycles 3..6.
        sent = 0; got = 0; held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 6) begin
                in_valid = 1'b1; a = 8'(30*sent + 7); b = 8'(50*sent); cin = sent[0];
            end else
                in_valid = 1'b0;
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                chk("bp_in_ready", 66'(in_ready), 66'(0));
                chk("bp_hold_valid", 66'(out_valid), 66'(1));
            end
            if (cyc >= 4 && cyc <= 6) chk("bp_frozen", 66'({cout, sum}), 66'(held));
            if (cyc == 3) held = {cout, sum};
            if (out_valid && out_ready) begin
                if (qb.size() == 0)
                    chk("bp_spurious", 66'(out_valid), 66'(0));
                else begin
                    e = qb.pop_front();
                    chk($sformatf("bp_beat%0d", got), {ovf, cout, 64'(sum)}, e);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                qb.push_back(ref_add(8, 64'(a), 64'(b), cin));
                sent++;
            end
            @(posedge clk); #1;
        end
        chk("bp_count", 66'(got), 66'(6));
        chk("bp_queue_empty", 66'(qb.size()), 66'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd9; b = 8'd9; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_inflight_valid", 66'(out_valid), 66'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 66'(out_valid), 66'(0));
        chk("mid_rst_sum", 66'(sum), 66'(0));
        chk("mid_rst_cout", 66'(cout), 66'(0));
        chk("mid_rst_in_ready", 66'(in_ready), 66'(1));
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_valid", i), 66'(out_valid), 66'(0));
            chk($sformatf("post_rst%0d_in_ready", i), 66'(in_ready), 66'(1));
        end

`ifdef CSA_SUB_EN
        op_sub = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd7; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'd128; b = 8'd1; cin = 1'b1;
        @(posedge clk); #1;
        chk("sub0_sum", 66'(sum), 66'(254));
        chk("sub0_cout", 66'(cout), 66'(0));
        chk("sub0_ovf", 66'(ovf), 66'(0));
        a = 8'd7; b = 8'd7; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sub1_sum", 66'(sum), 66'(127));
        chk("sub1_ovf", 66'(ovf), 66'(1));
        @(posedge clk); #1;
        chk("sub2_sum", 66'(sum), 66'(0));
        chk("sub2_cout", 66'(cout), 66'(1));
        op_sub = 1'b0;
        @(posedge clk); #1;
`endif

        // WIDTH=13 boundary: 8191 + 1 + 1 wraps to 1 with carry.
        in_valid13 = 1'b1; a13 = 13'd8191; b13 = 13'd1; cin13 = 1'b1;
        @(posedge clk); #1;
        in_valid13 = 1'b0;
        chk("w13s1_valid", 66'(out_valid_1), 66'(1));
        chk("w13s1_sum", 66'(sum_1), 66'(1));
        chk("w13s1_cout", 66'(cout_1), 66'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("w13s5_early", 66'(out_valid_5), 66'(0));
        @(posedge clk); #1;
        chk("w13s5_valid", 66'(out_valid_5), 66'(1));
        chk("w13s5_sum", 66'(sum_5), 66'(1));
        chk("w13s5_cout", 66'(cout_5), 66'(1));
        @(posedge clk); #1;

        // Random traffic on both 13-bit instances; S5 also sees random backpressure.
        for (int cyc = 0; cyc < 14000; cyc++) begin
            if (cyc < 13970) begin
                in_valid13  = ($urandom_range(0, 3) != 0);
                out_ready_5 = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid13  = 1'b0;
                out_ready_5 = 1'b1;
            end
            a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
            #1;
            if (out_valid_1) begin
                if (q1.size() == 0) chk("rnd1_spurious", 66'(out_valid_1), 66'(0));
                else begin
                    e = q1.pop_front();
                    chk("rnd1_beat", {ovf_1, cout_1, 64'(sum_1)}, e);
                end
            end
            if (out_valid_5 && out_ready_5) begin
                if (q5.size() == 0) chk("rnd5_spurious", 66'(out_valid_5), 66'(0));
                else begin
                    e = q5.pop_front();
                    chk("rnd5_beat", {ovf_5, cout_5, 64'(sum_5)}, e);
                end
            end
            if (in_valid13 && in_ready_1) q1.push_back(ref_add(13, 64'(a13), 64'(b13), cin13));
            if (in_valid13 && in_ready_5) q5.push_back(ref_add(13, 64'(a13), 64'(b13), cin13));
            @(posedge clk); #1;
        end
        chk("rnd1_drained", 66'(q1.size()), 66'(0));
        chk("rnd5_drained", 66'(q5.size()), 66'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
